// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// ALU/mux select codes and the decoded control word.
package mips_ctrl_pkg;

   localparam int unsigned OP_W    = 6;
   localparam int unsigned STATE_W = 4;

   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH  = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11,
      S_ILLEGAL = 4'd15
   } state_e;

   typedef struct packed {
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
      logic       pcwrite;
      logic       branch;
   } ctrl_word_t;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: opcode/flag inputs, control word and debug state.
interface mc_controller_if #(
   parameter int unsigned STATE_W = 4
);
   logic [5:0]         op;
   logic               zero;
   logic               iord;
   logic               memwrite;
   logic               irwrite;
   logic               regdst;
   logic               memtoreg;
   logic               regwrite;
   logic               alusrca;
   logic [1:0]         alusrcb;
   logic [1:0]         aluop;
   logic [1:0]         pcsrc;
   logic               pcen;
   logic [STATE_W-1:0] state;

   modport ctrl (
      input  op, zero,
      output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, aluop, pcsrc, pcen, state
   );

   modport dp (
      output op, zero,
      input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, aluop, pcsrc, pcen, state
   );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Moore decode of the FSM state into the datapath control word.
module mc_ctrl_outdec
   import mips_ctrl_pkg::*;
(
   input  state_e     i_state,
   output ctrl_word_t o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      case (i_state)
         S_FETCH: begin
            o_ctrl.irwrite = 1'b1;
            o_ctrl.alusrcb = SRCB_FOUR;
            o_ctrl.aluop   = ALUOP_ADD;
            o_ctrl.pcsrc   = PCSRC_ALU;
            o_ctrl.pcwrite = 1'b1;
         end
         S_DECODE: begin
            o_ctrl.alusrcb = SRCB_IMMSH;
            o_ctrl.aluop   = ALUOP_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            o_ctrl.alusrca = 1'b1;
            o_ctrl.alusrcb = SRCB_IMM;
            o_ctrl.aluop   = ALUOP_ADD;
         end
         S_MEMRD: o_ctrl.iord = 1'b1;
         S_MEMWB: begin
            o_ctrl.memtoreg = 1'b1;
            o_ctrl.regwrite = 1'b1;
         end
         S_MEMWR: begin
            o_ctrl.iord     = 1'b1;
            o_ctrl.memwrite = 1'b1;
         end
         S_RTYPEEX: begin
            o_ctrl.alusrca = 1'b1;
            o_ctrl.alusrcb = SRCB_B;
            o_ctrl.aluop   = ALUOP_FUNCT;
         end
         S_RTYPEWB: begin
            o_ctrl.regdst   = 1'b1;
            o_ctrl.regwrite = 1'b1;
         end
         S_BEQEX: begin
            o_ctrl.alusrca = 1'b1;
            o_ctrl.alusrcb = SRCB_B;
            o_ctrl.aluop   = ALUOP_SUB;
            o_ctrl.pcsrc   = PCSRC_ALUOUT;
            o_ctrl.branch  = 1'b1;
         end
         S_ADDIWB: o_ctrl.regwrite = 1'b1;
         S_JEX: begin
            o_ctrl.pcsrc   = PCSRC_JUMP;
            o_ctrl.pcwrite = 1'b1;
         end
         default: o_ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM: state register, next-state logic and pcen;
// the per-state control word comes from mc_ctrl_outdec.
module mc_controller
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned STATE_W      = 4,
   parameter int unsigned TRAP_ILLEGAL = 0
) (
   input  logic           clk,
   input  logic           reset,
   mc_controller_if.ctrl  bus
);

   state_e     r_state;
   state_e     w_next;
   ctrl_word_t w_ctrl;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH: w_next = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_RTYPE:     w_next = S_RTYPEEX;
               OP_BEQ:       w_next = S_BEQEX;
               OP_ADDI:      w_next = S_ADDIEX;
               OP_J:         w_next = S_JEX;
               default:      w_next = (TRAP_ILLEGAL != 0) ? S_ILLEGAL : S_FETCH;
            endcase
         end
         // op is re-read here; the IR holds it for the whole instruction
         S_MEMADR: begin
            if (bus.op == OP_SW)      w_next = S_MEMWR;
            else if (bus.op == OP_LW) w_next = S_MEMRD;
            else                      w_next = S_FETCH;
         end
         S_MEMRD:   w_next = S_MEMWB;
         S_RTYPEEX: w_next = S_RTYPEWB;
         S_ADDIEX:  w_next = S_ADDIWB;
         S_ILLEGAL: w_next = S_ILLEGAL;
         default:   w_next = S_FETCH;
      endcase
   end

   mc_ctrl_outdec u_outdec (
      .i_state (r_state),
      .o_ctrl  (w_ctrl)
   );

   assign bus.iord     = w_ctrl.iord;
   assign bus.memwrite = w_ctrl.memwrite;
   assign bus.irwrite  = w_ctrl.irwrite;
   assign bus.regdst   = w_ctrl.regdst;
   assign bus.memtoreg = w_ctrl.memtoreg;
   assign bus.regwrite = w_ctrl.regwrite;
   assign bus.alusrca  = w_ctrl.alusrca;
   assign bus.alusrcb  = w_ctrl.alusrcb;
   assign bus.aluop    = w_ctrl.aluop;
   assign bus.pcsrc    = w_ctrl.pcsrc;
   assign bus.pcen     = w_ctrl.pcwrite | (w_ctrl.branch & bus.zero);
   assign bus.state    = STATE_W'(r_state);

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: two instances (TRAP_ILLEGAL=0/1) run
// a cycle table plus hand sequences against a scoreboard of expected words.
module tb_mc_controller;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JJ = 6'b000010;
   localparam logic [5:0] XX = 6'b111111;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic       zero;

   always #5 clk = ~clk;

   mc_controller_if #(.STATE_W(4)) if0 ();
   mc_controller_if #(.STATE_W(4)) if1 ();

   assign if0.op = op;  assign if0.zero = zero;
   assign if1.op = op;  assign if1.zero = zero;

   mc_controller #(.STATE_W(4), .TRAP_ILLEGAL(0)) dut0 (.clk(clk), .reset(reset), .bus(if0.ctrl));
   mc_controller #(.STATE_W(4), .TRAP_ILLEGAL(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.ctrl));

   // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,aluop,pcsrc,pcen}
   logic [14:0] act0, act1;
   assign act0 = {if0.iord, if0.memwrite, if0.irwrite, if0.regdst, if0.memtoreg, if0.regwrite,
                  if0.alusrca, if0.alusrcb, if0.aluop, if0.pcsrc, if0.pcen};
   assign act1 = {if1.iord, if1.memwrite, if1.irwrite, if1.regdst, if1.memtoreg, if1.regwrite,
                  if1.alusrca, if1.alusrcb, if1.aluop, if1.pcsrc, if1.pcen};

   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic       zero;
      int         s0;
      int         s1;
   } vec_t;

   typedef struct {
      logic [3:0]  s0;
      logic [14:0] w0;
      logic [3:0]  s1;
      logic [14:0] w1;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   row   = 0;

   function automatic logic [14:0] exp_word(input int s, input logic z);
      case (s)
         0:  return 15'b0_0_1_0_0_0_0_01_00_00_1;
         1:  return 15'b0_0_0_0_0_0_0_11_00_00_0;
         2:  return 15'b0_0_0_0_0_0_1_10_00_00_0;
         3:  return 15'b1_0_0_0_0_0_0_00_00_00_0;
         4:  return 15'b0_0_0_0_1_1_0_00_00_00_0;
         5:  return 15'b1_1_0_0_0_0_0_00_00_00_0;
         6:  return 15'b0_0_0_0_0_0_1_00_10_00_0;
         7:  return 15'b0_0_0_1_0_1_0_00_00_00_0;
         8:  return {14'b0_0_0_0_0_0_1_00_01_01, z};
         9:  return 15'b0_0_0_0_0_0_1_10_00_00_0;
         10: return 15'b0_0_0_0_0_1_0_00_00_00_0;
         11: return 15'b0_0_0_0_0_0_0_00_00_10_1;
         default: return 15'b0;
      endcase
   endfunction

   task automatic push_exp(input int s0, input int s1);
      exp_t e;
      e.s0 = 4'(s0); e.w0 = exp_word(s0, zero);
      e.s1 = 4'(s1); e.w1 = exp_word(s1, zero);
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         total++; bad++;
         $display("FAIL scoreboard_empty row=%0d", row);
         return;
      end
      e = sb.pop_front();
      total++;
      if (if0.state !== e.s0) begin
         bad++; $display("FAIL state0 row=%0d got=%0d want=%0d", row, if0.state, e.s0);
      end
      total++;
      if (act0 !== e.w0) begin
         bad++; $display("FAIL ctrl0 row=%0d got=%b want=%b", row, act0, e.w0);
      end
      total++;
      if (if1.state !== e.s1) begin
         bad++; $display("FAIL state1 row=%0d got=%0d want=%0d", row, if1.state, e.s1);
      end
      total++;
      if (act1 !== e.w1) begin
         bad++; $display("FAIL ctrl1 row=%0d got=%b want=%b", row, act1, e.w1);
      end
   endtask

   // Drive one cycle's inputs at the falling edge and check the current state.
   task automatic step(input logic r, input logic [5:0] o, input logic z, input int s0, input int s1);
      @(negedge clk);
      reset = r; op = o; zero = z;
      push_exp(s0, s1);
      #1;
      check_out();
      row++;
   endtask

   vec_t vt[$];

   initial begin
      reset = 1'b1; op = LW; zero = 1'b0;
      vt = '{
         '{1'b1, LW, 1'b0, 0, 0},
         '{1'b0, LW, 1'b0, 0, 0}, '{1'b0, LW, 1'b0, 1, 1}, '{1'b0, LW, 1'b0, 2, 2},
         '{1'b0, LW, 1'b0, 3, 3}, '{1'b0, LW, 1'b0, 4, 4},
         '{1'b0, SW, 1'b0, 0, 0}, '{1'b0, SW, 1'b0, 1, 1}, '{1'b0, SW, 1'b0, 2, 2},
         '{1'b0, SW, 1'b0, 5, 5},
         '{1'b0, RT, 1'b0, 0, 0}, '{1'b0, RT, 1'b0, 1, 1}, '{1'b0, RT, 1'b0, 6, 6},
         '{1'b0, RT, 1'b0, 7, 7},
         '{1'b0, BQ, 1'b1, 0, 0}, '{1'b0, BQ, 1'b1, 1, 1}, '{1'b0, BQ, 1'b1, 8, 8},
         '{1'b0, BQ, 1'b0, 0, 0}, '{1'b0, BQ, 1'b0, 1, 1}, '{1'b0, BQ, 1'b0, 8, 8},
         '{1'b0, AI, 1'b0, 0, 0}, '{1'b0, AI, 1'b0, 1, 1}, '{1'b0, AI, 1'b0, 9, 9},
         '{1'b0, AI, 1'b0, 10, 10},
         '{1'b0, JJ, 1'b1, 0, 0}, '{1'b0, JJ, 1'b0, 1, 1}, '{1'b0, JJ, 1'b0, 11, 11},
         '{1'b0, XX, 1'b0, 0, 0}, '{1'b0, XX, 1'b0, 1, 1},
         '{1'b0, LW, 1'b1, 0, 15}, '{1'b0, LW, 1'b1, 1, 15}, '{1'b0, LW, 1'b0, 2, 15},
         '{1'b1, LW, 1'b0, 3, 15},
         '{1'b0, SW, 1'b0, 0, 0}, '{1'b0, SW, 1'b0, 1, 1}, '{1'b0, SW, 1'b0, 2, 2},
         '{1'b1, SW, 1'b0, 5, 5},
         '{1'b0, SW, 1'b0, 0, 0}, '{1'b0, SW, 1'b0, 1, 1}
      };

      repeat (2) @(posedge clk);
      for (int i = 0; i < vt.size(); i++)
         step(vt[i].rst, vt[i].op, vt[i].zero, vt[i].s0, vt[i].s1);

      // BEQ: pcen follows zero within the cycle, with no clock edge in between.
      step(1'b1, BQ, 1'b0, 2, 2);
      step(1'b0, BQ, 1'b0, 0, 0);
      step(1'b0, BQ, 1'b0, 1, 1);
      step(1'b0, BQ, 1'b0, 8, 8);
      zero = 1'b1;
      push_exp(8, 8);
      #1;
      check_out();
      row++;

      // J: pcen asserted in JEX regardless of zero.
      step(1'b0, JJ, 1'b1, 0, 0);
      step(1'b0, JJ, 1'b1, 1, 1);
      step(1'b0, JJ, 1'b0, 11, 11);
      step(1'b0, JJ, 1'b0, 0, 0);

      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
